// File: rtl/sail_read_line.sv
// sail_read_line: assembles an incoming byte stream into lines for Sail line-read builtins.
//
// One line is buffered at a time. Bytes are accepted while collecting; a newline, reaching
// MAX_LEN stored bytes, or in_last completes the line, which is then held on out_line/out_len
// until the consumer takes it. The byte input is stalled while a completed line waits.
// After the final line (in_last) is delivered the block parks in a sticky EOF state.
//
// Build option:
//   SAIL_READ_LINE_CR_STRIP_EN - when defined, accepted 0x0D bytes are discarded
//                                (still honour in_last); otherwise 0x0D is stored.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_data/in_last/out_ready       byte input handshake
//   out_line_valid/in_line_ready             line output handshake
//   out_line, out_len                        line bytes (byte i at [8i+7:8i]) and length
//   out_truncated, out_line_eof              line ended on MAX_LEN / is the final line
//   out_eof, out_line_count                  sticky end-of-input, delivered-line counter
module sail_read_line #(
    parameter int unsigned MAX_LEN = 64,
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 out_ready,
    output logic                 out_line_valid,
    input  logic                 in_line_ready,
    output logic [MAX_LEN*8-1:0] out_line,
    output logic [LEN_W-1:0]     out_len,
    output logic                 out_truncated,
    output logic                 out_line_eof,
    output logic                 out_eof,
    output logic [15:0]          out_line_count
);

    typedef enum logic [1:0] {StCollect, StFull, StEof} state_e;

    state_e               r_state;
    logic [MAX_LEN*8-1:0] r_buf;
    logic [LEN_W-1:0]     r_len;
    logic                 r_trunc;
    logic                 r_eof_pending;
    logic [15:0]          r_count;

    logic             w_is_nl;
    logic             w_is_cr;
    logic             w_store;
    logic             w_hit_max;
    logic             w_complete;
    logic [LEN_W-1:0] w_len_inc;

    assign w_is_nl = (in_data == 8'h0A);
`ifdef SAIL_READ_LINE_CR_STRIP_EN
    assign w_is_cr = (in_data == 8'h0D);
`else
    assign w_is_cr = 1'b0;
`endif
    assign w_store    = !w_is_nl && !w_is_cr;
    assign w_len_inc  = r_len + 1'b1;
    assign w_hit_max  = w_store && (w_len_inc == LEN_W'(MAX_LEN));
    assign w_complete = w_is_nl || w_hit_max || in_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StCollect;
            r_buf         <= '0;
            r_len         <= '0;
            r_trunc       <= 1'b0;
            r_eof_pending <= 1'b0;
            r_count       <= '0;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (in_valid) begin
                        if (w_store) begin
                            r_buf[int'(r_len)*8 +: 8] <= in_data;
                            r_len                     <= w_len_inc;
                        end
                        if (w_complete) begin
                            r_state       <= StFull;
                            r_trunc       <= w_hit_max;
                            r_eof_pending <= in_last;
                        end
                    end
                end
                StFull: begin
                    if (in_line_ready) begin
                        // Clearing here keeps bytes beyond out_len at zero for the next line.
                        r_buf   <= '0;
                        r_len   <= '0;
                        r_trunc <= 1'b0;
                        r_count <= r_count + 16'd1;
                        r_state <= r_eof_pending ? StEof : StCollect;
                    end
                end
                StEof: begin
                    r_state <= StEof;
                end
                default: begin
                    r_state <= StCollect;
                end
            endcase
        end
    end

    // Gated by rst_n so the byte input is not advertised while reset is held.
    assign out_ready      = rst_n && (r_state == StCollect);
    assign out_line_valid = (r_state == StFull);
    assign out_line       = r_buf;
    assign out_len        = r_len;
    assign out_truncated  = r_trunc;
    assign out_line_eof   = (r_state == StFull) && r_eof_pending;
    assign out_eof        = (r_state == StEof);
    assign out_line_count = r_count;

endmodule

// File: doc/sail_read_line.md
Name: sail_read_line

Overview:
Input-side counterpart of the Sail stdout print path. It consumes a byte stream, such as a testbench stdin feeder or a UART RX FIFO, and assembles bytes into lines. Each completed line is presented as a packed byte vector plus a length, through a valid/ready handshake, to Sail-generated logic that implements line-read builtins. One line is buffered at a time, and the byte input is back-pressured while a completed line waits for its consumer.

Parameters:
MAX_LEN, 64, maximum stored bytes per line; must be >= 2.
LEN_W, $clog2(MAX_LEN+1), width of the length output; derived, not overridden.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  a byte is offered on in_data.
in_data  input  8  offered byte.
in_last  input  1  the offered byte is the final byte of input.
out_ready  output  1  byte accepted when in_valid && out_ready.
out_line_valid  output  1  a completed line is presented.
in_line_ready  input  1  consumer takes the line when out_line_valid && in_line_ready.
out_line  output  MAX_LEN*8  line bytes; byte i at bits [8i+7:8i]; bytes at index >= out_len read 0x00.
out_len  output  LEN_W  number of valid bytes in out_line.
out_truncated  output  1  line ended because MAX_LEN was reached.
out_line_eof  output  1  this is the final line of input.
out_eof  output  1  input exhausted and last line delivered; sticky.
out_line_count  output  16  lines delivered; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, rst_n=0):
  - State COLLECT.
  - Buffer all zero, len 0, eof_pending 0.
  - All outputs 0 except out_ready=1 once rst_n deasserts.
- States:
  - COLLECT: out_ready=1, out_line_valid=0.
  - FULL: out_ready=0, out_line_valid=1.
  - EOF: out_ready=0, out_line_valid=0, out_eof=1.
- Byte handling in COLLECT, on each accepted byte b:
  - b == 0x0A: not stored; line completes, out_truncated=0.
  - Otherwise: b is stored at index len and len increments. If len reaches MAX_LEN, the line completes with out_truncated=1.
  - in_last=1: line completes regardless of len (a length-0 line is legal) and eof_pending is set. Newline and truncation rules for b still apply.
  - If the line completes: state -> FULL on the next edge.
  - Latency: out_line_valid rises in the cycle after the completing byte is accepted.
- FULL:
  - out_line, out_len, out_truncated and out_line_eof (= eof_pending) stay stable until handoff.
  - On handoff: buffer cleared to zero, len=0, out_truncated=0, out_line_count+1.
  - After handoff: state -> EOF if eof_pending, else COLLECT.
  - out_ready rises the cycle after handoff, giving one dead cycle per line.
- EOF: terminal; only reset leaves it. in_valid is ignored.
- Empty line ("\n" alone): valid line, out_len=0, out_line all zero.
- No byte is ever dropped or duplicated; bytes are never accepted in FULL or EOF.
- Reset mid-line or mid-handoff: the partial line is discarded, the counter is cleared, and the block restarts in COLLECT.

Optional Feature:
SAIL_READ_LINE_CR_STRIP_EN:
- Defined: an accepted 0x0D byte is discarded, not stored and not counted. If it carries in_last=1, it still completes the line and sets eof_pending.
- Undefined: 0x0D is stored as an ordinary byte.

Test Plan:
- Feed 0x68,0x69,0x0A with in_line_ready=0 -> one cycle after 0x0A: out_line_valid=1, out_len=2, out_line[15:0]=0x6968, upper bytes 0, out_truncated=0, out_line_eof=0, out_ready=0. Hold for 10 cycles -> outputs stable. Raise in_line_ready -> out_line_count=1, out_ready=1 the next cycle.
- MAX_LEN=4, feed "abcdef\n" with in_line_ready=1 -> line 1 "abcd", len 4, truncated=1. Line 2 "ef" (0x6665), len 2, truncated=0. Count 2; byte stalls only during FULL and dead cycles.
- Feed "\n" then 'x' with in_last=1 -> line A len 0. Line B len 1, byte 0x78, out_line_eof=1. After handoff: out_eof=1, out_ready=0; further in_valid ignored for 20 cycles.
- Feed 0x61,0x0D,0x0A -> with SAIL_READ_LINE_CR_STRIP_EN: len 1, bytes 0x61. Without it: len 2, bytes 0x61,0x0D.
- Pulse rst_n low after 3 bytes of a line, asynchronously mid-cycle -> outputs 0 immediately. After release: out_ready=1, count 0, and the next "z\n" yields len 1, byte 0x7A.
- Count wrap: force count to 0xFFFF (or deliver 65536 empty lines) -> next handoff gives 0x0000.
